// File: rtl/bt_ast_pkg.sv
// -----------------------------------------------------------------------------
// bt_ast_pkg
// Shared types and constants for the BT.656 Avalon-ST frame arbiter.
//   arb_state_t     : arbitration FSM states
//   PKT_TYPE_CTRL   : packet type nibble of a control packet
//   PKT_TYPE_VIDEO  : packet type nibble of a video packet
//   is_ctrl_sop()   : true when a head beat opens a control packet
// -----------------------------------------------------------------------------
package bt_ast_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        GAP,
        VIDEO,
        CLOSE
    } arb_state_t;

    localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

    function automatic logic is_ctrl_sop(input logic valid, input logic sop,
                                         input logic [3:0] ptype);
        return valid && sop && (ptype == PKT_TYPE_CTRL);
    endfunction

endpackage

// File: rtl/ast_out_reg.sv
// -----------------------------------------------------------------------------
// ast_out_reg
// Registered Avalon-ST source stage (one cycle latency, ready latency 0).
// Ports:
//   clock, reset_n         : clock, asynchronous active-low reset
//   load                   : a beat is presented for capture (only when free)
//   load_data/sop/eop      : beat contents to capture
//   dout_ready             : downstream ready
//   free                   : register can take a beat this cycle
//   dout_data/valid/sop/eop: registered source outputs
// -----------------------------------------------------------------------------
module ast_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_sop,
    input  logic                  load_eop,
    input  logic                  dout_ready,
    output logic                  free,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket
);

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  sop_p1;
    logic                  eop_p1;

    assign free = !vld_p1 || dout_ready;

    // Stage p1: output register; holds its beat while downstream stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sop_p1  <= 1'b0;
            eop_p1  <= 1'b0;
        end else if (free) begin
            vld_p1 <= load;
            if (load) begin
                data_p1 <= load_data;
                sop_p1  <= load_sop;
                eop_p1  <= load_eop;
            end
        end
    end

    assign dout_data          = data_p1;
    assign dout_valid         = vld_p1;
    assign dout_startofpacket = sop_p1;
    assign dout_endofpacket   = eop_p1;

endmodule

// File: rtl/ast_frame_arbiter.sv
// -----------------------------------------------------------------------------
// ast_frame_arbiter
// Frame-granular arbiter sharing one Avalon-ST source between two BT.656
// capture channels. A frame is a control packet (type F) followed by a video
// packet (type 0); the grant only changes between frames.
// Ports:
//   clock, reset_n               : clock, asynchronous active-low reset
//   sel_mode, sel_fixed          : 0 = fixed source sel_fixed, 1 = round-robin
//   in0_* / in1_*                : Avalon-ST sinks (ready latency 0)
//   dout_*                       : Avalon-ST source (registered)
//   active_src                   : source currently or last granted
//   frame_count                  : completed video packets (wraps)
//   timeout_pulse                : one-cycle pulse when the watchdog closes a frame
// Build option:
//   DROP_UNSELECTED_EN : the non-granted input is drained and discarded instead
//                        of being back-pressured.
// -----------------------------------------------------------------------------
module ast_frame_arbiter
    import bt_ast_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_WIDTH       = 21
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sel_mode,
    input  logic                  sel_fixed,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    input  logic                  in0_startofpacket,
    input  logic                  in0_endofpacket,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    input  logic                  in1_startofpacket,
    input  logic                  in1_endofpacket,
    output logic                  in1_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic                  active_src,
    output logic [15:0]           frame_count,
    output logic                  timeout_pulse
);

    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t            state, next_state;
    logic                  grant, next_grant;
    logic                  last_src;
    logic                  pkt_open;
    logic [TO_WIDTH-1:0]   wd_cnt;

    logic [DATA_WIDTH-1:0] in_data [2];
    logic [1:0]            in_valid, in_sop, in_eop, in_ready;
    logic [1:0]            ctrl_sop, cand, elig;

    logic                  free, load, ld_sop, ld_eop;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  in_frame, acc, wd_expired, frame_done, pulse_set;
    logic [3:0]            g_type;

    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in_valid   = {in1_valid, in0_valid};
    assign in_sop     = {in1_startofpacket, in0_startofpacket};
    assign in_eop     = {in1_endofpacket, in0_endofpacket};
    assign ctrl_sop[0] = is_ctrl_sop(in0_valid, in0_startofpacket, in0_data[3:0]);
    assign ctrl_sop[1] = is_ctrl_sop(in1_valid, in1_startofpacket, in1_data[3:0]);

    assign in0_ready  = in_ready[0];
    assign in1_ready  = in_ready[1];
    assign active_src = grant;

    always_comb begin
        next_state = state;
        next_grant = grant;
        in_ready   = 2'b00;
        load       = 1'b0;
        ld_data    = in_data[grant];
        ld_sop     = in_sop[grant];
        ld_eop     = in_eop[grant];
        frame_done = 1'b0;
        pulse_set  = 1'b0;
        g_type     = in_data[grant][3:0];
        cand       = sel_mode ? 2'b11 : (sel_fixed ? 2'b10 : 2'b01);
        elig       = cand & ctrl_sop;
        in_frame   = (state == CTRL) || (state == GAP) || (state == VIDEO);
        acc        = in_frame && in_valid[grant] && free;
        // A stalled output pauses the watchdog, so it can only expire when free.
        wd_expired = in_frame && free && !acc && (wd_cnt == WD_LAST);

        case (state)
            IDLE: begin
                // Grant without consuming: the ctrl SOP is forwarded from CTRL.
                // Candidate heads that are not a ctrl SOP are drained to resync.
                in_ready = cand & in_valid & ~ctrl_sop;
                if (elig == 2'b11) begin
                    next_grant = !last_src;
                    next_state = CTRL;
                end else if (elig[0]) begin
                    next_grant = 1'b0;
                    next_state = CTRL;
                end else if (elig[1]) begin
                    next_grant = 1'b1;
                    next_state = CTRL;
                end
            end
            CTRL: begin
                in_ready[grant] = free;
                if (acc) begin
                    load = 1'b1;
                    if (in_eop[grant]) next_state = GAP;
                end else if (wd_expired) begin
                    next_state = CLOSE;
                end
            end
            GAP: begin
                // Only a new SOP is forwarded; stray non-SOP beats are dropped.
                in_ready[grant] = free;
                if (acc) begin
                    if (in_sop[grant]) begin
                        load = 1'b1;
                        if (g_type == PKT_TYPE_VIDEO) begin
                            if (in_eop[grant]) begin
                                frame_done = 1'b1;
                                next_state = IDLE;
                            end else begin
                                next_state = VIDEO;
                            end
                        end else if (!in_eop[grant]) begin
                            next_state = CTRL;
                        end
                    end
                end else if (wd_expired) begin
                    next_state = CLOSE;
                end
            end
            VIDEO: begin
                in_ready[grant] = free;
                if (acc) begin
                    load = 1'b1;
                    if (in_eop[grant]) begin
                        frame_done = 1'b1;
                        next_state = IDLE;
                    end
                end else if (wd_expired) begin
                    next_state = CLOSE;
                end
            end
            CLOSE: begin
                // Terminate an open packet with a synthetic EOP beat.
                if (!pkt_open || free) begin
                    load       = pkt_open;
                    ld_data    = '0;
                    ld_sop     = 1'b0;
                    ld_eop     = 1'b1;
                    pulse_set  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

`ifdef DROP_UNSELECTED_EN
        if (state == IDLE) begin
            in_ready = in_ready | (~cand & in_valid);
        end else begin
            in_ready[!grant] = in_valid[!grant];
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_src      <= 1'b1;
            pkt_open      <= 1'b0;
            wd_cnt        <= '0;
            frame_count   <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= next_state;
            grant         <= next_grant;
            timeout_pulse <= pulse_set;
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
                last_src    <= grant;
            end
            if (load) begin
                if (ld_eop) pkt_open <= 1'b0;
                else if (ld_sop) pkt_open <= 1'b1;
            end
            if (!in_frame || acc) wd_cnt <= '0;
            else if (free) wd_cnt <= wd_cnt + TO_WIDTH'(1);
        end
    end

    // Stage p0 -> p1: selected beat into the output register.
    ast_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clock              (clock),
        .reset_n            (reset_n),
        .load               (load),
        .load_data          (ld_data),
        .load_sop           (ld_sop),
        .load_eop           (ld_eop),
        .dout_ready         (dout_ready),
        .free               (free),
        .dout_data          (dout_data),
        .dout_valid         (dout_valid),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket)
    );

endmodule

// File: tb/tb_ast_frame_arbiter.sv
module tb_ast_frame_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       fc;
    } beat_t;

`ifdef DROP_UNSELECTED_EN
    localparam bit EXP_DROP = 1'b1;
`else
    localparam bit EXP_DROP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel_mode = 1'b0, sel_fixed = 1'b0, dout_ready = 1'b1;
    logic [7:0]  in_data [2];
    logic        in_valid [2];
    logic        in_sop [2];
    logic        in_eop [2];
    logic        in0_ready, in1_ready;
    logic [7:0]  dout_data;
    logic        dout_valid, dout_sop, dout_eop;
    logic        active_src, timeout_pulse;
    logic [15:0] frame_count;

    int    n_tests = 0, n_fail = 0;
    int    model_fc = 0, pulse_cnt = 0;
    bit    rnd_ready = 1'b0, lat_on = 1'b0, lat_pend = 1'b0, abort = 1'b0;
    bit    prev_stall = 1'b0, t6_done;
    logic [9:0] prev_out, lat_beat;
    beat_t q0[$], q1[$], exp_q[$];
    bit    seen_src[$];

    ast_frame_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .TO_WIDTH(5)) dut (
        .clock(clock), .reset_n(reset_n), .sel_mode(sel_mode), .sel_fixed(sel_fixed),
        .in0_data(in_data[0]), .in0_valid(in_valid[0]), .in0_startofpacket(in_sop[0]),
        .in0_endofpacket(in_eop[0]), .in0_ready(in0_ready),
        .in1_data(in_data[1]), .in1_valid(in_valid[1]), .in1_startofpacket(in_sop[1]),
        .in1_endofpacket(in_eop[1]), .in1_ready(in1_ready),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_startofpacket(dout_sop),
        .dout_endofpacket(dout_eop), .dout_ready(dout_ready),
        .active_src(active_src), .frame_count(frame_count), .timeout_pulse(timeout_pulse)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic void chk(input bit ok, input string nm, input longint act, input longint expv);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    function automatic void push_src(input int s, input beat_t b);
        if (s == 0) q0.push_back(b);
        else q1.push_back(b);
    endfunction

    // One frame: ctrl packet of clen beats then video packet of vlen beats.
    // fwd: beats belong to the expected output stream; open: video has no EOP.
    function automatic void build_frame(input int s, input int clen, input int vlen,
                                        input bit fwd, input bit open);
        beat_t b;
        for (int i = 0; i < clen; i++) begin
            b.d   = (i == 0) ? {4'($urandom), 4'hF} : 8'($urandom);
            b.sop = (i == 0);
            b.eop = (i == clen - 1);
            b.fc  = 1'b0;
            push_src(s, b);
            if (fwd) exp_q.push_back(b);
        end
        for (int i = 0; i < vlen; i++) begin
            b.d   = (i == 0) ? {4'($urandom), 4'h0} : 8'($urandom);
            b.sop = (i == 0);
            b.eop = (i == vlen - 1) && !open;
            b.fc  = b.eop;
            push_src(s, b);
            if (fwd) exp_q.push_back(b);
        end
    endfunction

    task automatic send_beat(input int s, input beat_t b);
        int n = 0;
        if (abort) return;
        in_data[s] = b.d; in_sop[s] = b.sop; in_eop[s] = b.eop; in_valid[s] = 1'b1;
        forever begin
            @(negedge clock);
            if ((s == 0) ? in0_ready : in1_ready) break;
            n++;
            if (n > 5000) begin
                chk(1'b0, "beat_accept_bound", n, 5000);
                abort = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        in_valid[s] = 1'b0;
    endtask

    task automatic drain(input int s, input int gapmax);
        beat_t b;
        bit more;
        more = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
        while (more) begin
            if (s == 0) b = q0.pop_front();
            else b = q1.pop_front();
            send_beat(s, b);
            more = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (more) repeat ($urandom_range(0, gapmax)) begin @(posedge clock); #1; end
        end
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clock); n++; end
        #1;
        chk(exp_q.size() == 0, nm, exp_q.size(), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0; in_data[i] = 8'h00;
        end
        repeat (2) @(negedge clock);
        chk(dout_valid == 1'b0, "reset_dout_valid", dout_valid, 0);
        chk(frame_count == 16'd0, "reset_frame_count", frame_count, 0);
        chk(active_src == 1'b0, "reset_active_src", active_src, 0);
        chk({dout_data, dout_sop, dout_eop, timeout_pulse, in0_ready, in1_ready} == 13'd0,
            "reset_other_outputs", {dout_data, dout_sop, dout_eop, timeout_pulse, in0_ready, in1_ready}, 0);
        @(posedge clock); #1;
        exp_q.delete(); q0.delete(); q1.delete();
        model_fc = 0;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    // Downstream ready: always 1 or 50% random.
    initial forever begin
        @(posedge clock); #1;
        dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) if (reset_n && timeout_pulse) pulse_cnt++;

    // Output scoreboard: every delivered beat against the expected stream,
    // plus stability of a beat held under backpressure.
    always @(negedge clock) begin
        beat_t e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk(dout_valid && ({dout_data, dout_sop, dout_eop} == prev_out), "hold_under_stall",
                    {dout_valid, dout_data, dout_sop, dout_eop}, {1'b1, prev_out});
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {dout_data, dout_sop, dout_eop}, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk({dout_data, dout_sop, dout_eop} == {e.d, e.sop, e.eop}, "beat",
                        {dout_data, dout_sop, dout_eop}, {e.d, e.sop, e.eop});
                    if (e.fc) begin
                        model_fc++;
                        chk(frame_count == 16'(model_fc), "frame_count_track", frame_count, model_fc);
                    end
                    if (e.sop && e.d[3:0] == 4'hF) seen_src.push_back(active_src);
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_out   = {dout_data, dout_sop, dout_eop};
        end
    end

    // One-cycle latency from an accepted in0 beat to its appearance on dout.
    always @(negedge clock) begin
        if (lat_on && reset_n) begin
            if (lat_pend)
                chk(dout_valid && ({dout_data, dout_sop, dout_eop} == lat_beat), "latency_1cycle",
                    {dout_valid, dout_data, dout_sop, dout_eop}, {1'b1, lat_beat});
            lat_pend = in_valid[0] && in0_ready;
            lat_beat = {in_data[0], in_sop[0], in_eop[0]};
        end else begin
            lat_pend = 1'b0;
        end
    end

    initial begin
        int n, p0;
        beat_t syn;
        do_reset();

        // Single source, fixed mode, full-size frame.
        sel_mode = 1'b0; sel_fixed = 1'b0;
        lat_on = 1'b1;
        build_frame(0, 9, 1280, 1'b1, 1'b0);
        drain(0, 3);
        wait_empty("t1_drain");
        lat_on = 1'b0;
        chk(frame_count == 16'd1, "t1_frame_count", frame_count, 1);
        chk(active_src == 1'b0, "t1_active_src", active_src, 0);

        // Round-robin, both channels present a ctrl SOP in the same cycle.
        do_reset();
        sel_mode = 1'b1;
        seen_src.delete();
        build_frame(0, 9, 64, 1'b1, 1'b0);
        build_frame(1, 9, 64, 1'b1, 1'b0);
`ifdef DROP_UNSELECTED_EN
        drain(0, 2);
        drain(1, 2);
`else
        fork
            drain(0, 2);
            drain(1, 2);
        join
`endif
        wait_empty("t2_drain");
        chk(frame_count == 16'd2, "t2_frame_count", frame_count, 2);
        chk(seen_src.size() == 2, "t2_frames_seen", seen_src.size(), 2);
        if (seen_src.size() == 2) begin
            chk(seen_src[0] == 1'b0, "t2_first_src", seen_src[0], 0);
            chk(seen_src[1] == 1'b1, "t2_second_src", seen_src[1], 1);
        end

        // Random downstream backpressure; watchdog must stay quiet.
        sel_mode = 1'b0; sel_fixed = 1'b0;
        p0 = pulse_cnt;
        rnd_ready = 1'b1;
        build_frame(0, 9, 128, 1'b1, 1'b0);
        build_frame(0, 9, 128, 1'b1, 1'b0);
        drain(0, 3);
        wait_empty("t3_drain");
        rnd_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk(pulse_cnt == p0, "t3_no_timeout", pulse_cnt, p0);
        chk(frame_count == 16'd4, "t3_frame_count", frame_count, 4);

        // Source stalls mid-video: forced close with a synthetic EOP.
        p0 = pulse_cnt;
        build_frame(0, 9, 20, 1'b1, 1'b1);
        syn.d = 8'h00; syn.sop = 1'b0; syn.eop = 1'b1; syn.fc = 1'b0;
        exp_q.push_back(syn);
        drain(0, 1);
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            n++;
            if (dout_valid && dout_eop && !dout_sop && dout_data == 8'h00) break;
        end
        chk(n >= 16 && n <= 18, "t4_close_delay", n, 17);
        wait_empty("t4_drain");
        chk(pulse_cnt == p0 + 1, "t4_one_pulse_cycle", pulse_cnt - p0, 1);
        chk(frame_count == 16'd4, "t4_frame_count_held", frame_count, 4);

        // in1 starts mid-stream with a video packet: discarded until ctrl SOP.
        sel_fixed = 1'b1;
        build_frame(1, 0, 6, 1'b0, 1'b0);
        build_frame(1, 9, 32, 1'b1, 1'b0);
        drain(1, 2);
        wait_empty("t5_drain");
        chk(frame_count == 16'd5, "t5_frame_count", frame_count, 5);
        chk(active_src == 1'b1, "t5_active_src", active_src, 1);

        // in1 streams while in0 owns the output.
        sel_fixed = 1'b0;
        build_frame(0, 9, 32, 1'b1, 1'b0);
        in_data[1] = 8'h35; in_sop[1] = 1'b0; in_eop[1] = 1'b0; in_valid[1] = 1'b1;
        t6_done = 1'b0;
        fork
            begin
                drain(0, 2);
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    @(negedge clock);
                    if (!t6_done) chk(in1_ready == EXP_DROP, "t6_in1_ready", in1_ready, EXP_DROP);
                end
            end
        join
        in_valid[1] = 1'b0;
        wait_empty("t6_drain");
        chk(frame_count == 16'd6, "t6_frame_count", frame_count, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
